// File: rtl/vtg_video_if.sv
`default_nettype none
// ============================================================================
//  Module   : vtg_video_if
//  Brief    : Parallel video bus (syncs, data enable, RGB) between a timing
//             source (master) and a video sink (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface vtg_video_if #(
  parameter int CW = 8
) ();

  logic          vs;
  logic          hs;
  logic          den;
  logic [CW-1:0] r;
  logic [CW-1:0] g;
  logic [CW-1:0] b;

  modport master (output vs, hs, den, r, g, b);
  modport slave  (input  vs, hs, den, r, g, b);

endinterface
`default_nettype wire

// File: rtl/vtg_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vtg_pattern_gen
//  Brief    : Parametrised video timing and test-pattern generator. Drives
//             vs/hs/den/RGB with runtime pattern select (solid, colour bars,
//             ramp, checker), a completed-frame counter and a frame-done pulse.
//  Options  : VTG_FRAME_STOP_EN - adds frame_limit input and stopped output;
//             generation halts once frame_cnt reaches a nonzero frame_limit.
//  Revision : 1.0 - initial release
// ============================================================================
module vtg_pattern_gen #(
  parameter int H_ACT  = 1024,
  parameter int H_FP   = 24,
  parameter int H_SW   = 136,
  parameter int H_BP   = 160,
  parameter int V_ACT  = 768,
  parameter int V_FP   = 3,
  parameter int V_SW   = 6,
  parameter int V_BP   = 29,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0,
  parameter int CW     = 8,
  parameter int FCW    = 10
) (
  input  wire logic            clk,
  input  wire logic            rstb,
  input  wire logic            en,
  input  wire logic [1:0]      pat_sel,
  input  wire logic [3*CW-1:0] solid_rgb,
`ifdef VTG_FRAME_STOP_EN
  input  wire logic [FCW-1:0]  frame_limit,
  output logic                 stopped,
`endif
  vtg_video_if.master          vid,
  output logic [FCW-1:0]       frame_cnt,
  output logic                 frame_done
);

  // --------------------------------------------------------------------------
  // Derived timing constants. Counter widths hold HTOT/VTOT themselves so the
  // sync-end boundaries never overflow even with a zero back porch.
  // --------------------------------------------------------------------------
  localparam int c_HTOT = H_ACT + H_FP + H_SW + H_BP;
  localparam int c_VTOT = V_ACT + V_FP + V_SW + V_BP;
  localparam int c_HW   = $clog2(c_HTOT + 1);
  localparam int c_VW   = $clog2(c_VTOT + 1);

  // Pattern x coordinate is widened so ramp (CW bits) and checker (bit 4)
  // can always index it.
  localparam int c_XW0  = (c_HW > CW) ? c_HW : CW;
  localparam int c_XW   = (c_XW0 > 5) ? c_XW0 : 5;

  // Bar width; narrow rasters fall back to 1-pixel bars.
  localparam int c_BW   = ((H_ACT / 8) > 0) ? (H_ACT / 8) : 1;

  localparam logic [c_HW-1:0] c_H_ACT  = c_HW'(H_ACT);
  localparam logic [c_HW-1:0] c_HS_BEG = c_HW'(H_ACT + H_FP);
  localparam logic [c_HW-1:0] c_HS_END = c_HW'(H_ACT + H_FP + H_SW);
  localparam logic [c_HW-1:0] c_H_LAST = c_HW'(c_HTOT - 1);
  localparam logic [c_VW-1:0] c_V_ACT  = c_VW'(V_ACT);
  localparam logic [c_VW-1:0] c_VS_BEG = c_VW'(V_ACT + V_FP);
  localparam logic [c_VW-1:0] c_VS_END = c_VW'(V_ACT + V_FP + V_SW);
  localparam logic [c_VW-1:0] c_V_LAST = c_VW'(c_VTOT - 1);

  localparam logic c_HS_ON = (HS_POL != 0);
  localparam logic c_VS_ON = (VS_POL != 0);

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [c_HW-1:0] r_hcnt;
  logic [c_VW-1:0] r_vcnt;
  logic [1:0]      r_pat;
  logic [3*CW-1:0] r_solid;

  logic            w_run;
  logic            w_h_last;
  logic            w_v_last;
  logic            w_frame_end;
  logic            w_origin;
  logic [1:0]      w_pat;
  logic [3*CW-1:0] w_solid;
  logic            w_den;
  logic            w_hs_on;
  logic            w_vs_on;
  logic [c_XW-1:0] w_x;
  logic            w_y4;
  logic [2:0]      w_bar_idx;
  logic [2:0]      w_bar_mask;
  logic [CW-1:0]   w_r;
  logic [CW-1:0]   w_g;
  logic [CW-1:0]   w_b;
  logic [FCW-1:0]  w_fc_nxt;

  // --------------------------------------------------------------------------
  // Run qualification and counter decodes
  // --------------------------------------------------------------------------
`ifdef VTG_FRAME_STOP_EN
  assign w_run = en & ~stopped;
`else
  assign w_run = en;
`endif

  assign w_h_last    = (r_hcnt == c_H_LAST);
  assign w_v_last    = (r_vcnt == c_V_LAST);
  assign w_frame_end = w_h_last & w_v_last;
  assign w_origin    = (r_hcnt == '0) && (r_vcnt == '0);
  assign w_fc_nxt    = frame_cnt + FCW'(1);

  assign w_den   = (r_hcnt < c_H_ACT) && (r_vcnt < c_V_ACT);
  assign w_hs_on = (r_hcnt >= c_HS_BEG) && (r_hcnt < c_HS_END);
  assign w_vs_on = (r_vcnt >= c_VS_BEG) && (r_vcnt < c_VS_END);

  // The first pixel of a frame already uses the selection being latched on
  // that edge, so a new pattern starts cleanly at (0,0).
  assign w_pat   = w_origin ? pat_sel   : r_pat;
  assign w_solid = w_origin ? solid_rgb : r_solid;

  assign w_x = c_XW'(r_hcnt);

  generate
    if (c_VW > 4) begin : g_y4_bit
      assign w_y4 = r_vcnt[4];
    end else begin : g_y4_zero
      assign w_y4 = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Raster counters: held at the origin while not running
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (!w_run) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_h_last) begin
      r_hcnt <= '0;
      r_vcnt <= w_v_last ? '0 : r_vcnt + c_VW'(1);
    end else begin
      r_hcnt <= r_hcnt + c_HW'(1);
    end
  end

  // Pattern selection is frame-synchronous: captured only at the origin
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_pat   <= '0;
      r_solid <= '0;
    end else if (w_run && w_origin) begin
      r_pat   <= pat_sel;
      r_solid <= solid_rgb;
    end
  end

  // Frame bookkeeping: done pulse and completed-frame count on the last pixel
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
`ifdef VTG_FRAME_STOP_EN
      stopped    <= 1'b0;
`endif
    end else begin
      frame_done <= w_run & w_frame_end;
`ifdef VTG_FRAME_STOP_EN
      if (!en) begin
        stopped   <= 1'b0;
        frame_cnt <= '0;
      end else if (w_run && w_frame_end) begin
        frame_cnt <= w_fc_nxt;
        if ((frame_limit != '0) && (w_fc_nxt == frame_limit)) begin
          stopped <= 1'b1;
        end
      end
`else
      if (w_run && w_frame_end) begin
        frame_cnt <= w_fc_nxt;
      end
`endif
    end
  end

  // Colour-bar index: number of bar boundaries at or left of x, capped at 7
  // so the last bar absorbs any remainder.
  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (w_x >= c_XW'(k * c_BW)) begin
        w_bar_idx = w_bar_idx + 3'd1;
      end
    end
  end

  // Bar colour as {r,g,b} on/off: white, yellow, cyan, green, magenta, red,
  // blue, black
  always_comb begin
    w_bar_mask = 3'b000;
    case (w_bar_idx)
      3'd0:    w_bar_mask = 3'b111;
      3'd1:    w_bar_mask = 3'b110;
      3'd2:    w_bar_mask = 3'b011;
      3'd3:    w_bar_mask = 3'b010;
      3'd4:    w_bar_mask = 3'b101;
      3'd5:    w_bar_mask = 3'b100;
      3'd6:    w_bar_mask = 3'b001;
      default: w_bar_mask = 3'b000;
    endcase
  end

  // Pixel colour for the current raster position and selected pattern
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (w_pat)
      2'd0: begin
        w_r = w_solid[3*CW-1:2*CW];
        w_g = w_solid[2*CW-1:CW];
        w_b = w_solid[CW-1:0];
      end
      2'd1: begin
        w_r = {CW{w_bar_mask[2]}};
        w_g = {CW{w_bar_mask[1]}};
        w_b = {CW{w_bar_mask[0]}};
      end
      2'd2: begin
        w_r = w_x[CW-1:0];
        w_g = w_x[CW-1:0];
        w_b = w_x[CW-1:0];
      end
      default: begin
        w_r = {CW{w_x[4] ^ w_y4}};
        w_g = {CW{w_x[4] ^ w_y4}};
        w_b = {CW{w_x[4] ^ w_y4}};
      end
    endcase
  end

  // Registered video outputs: one clock behind the counters, idle when halted
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      vid.den <= 1'b0;
      vid.hs  <= ~c_HS_ON;
      vid.vs  <= ~c_VS_ON;
      vid.r   <= '0;
      vid.g   <= '0;
      vid.b   <= '0;
    end else if (!w_run) begin
      vid.den <= 1'b0;
      vid.hs  <= ~c_HS_ON;
      vid.vs  <= ~c_VS_ON;
      vid.r   <= '0;
      vid.g   <= '0;
      vid.b   <= '0;
    end else begin
      vid.den <= w_den;
      vid.hs  <= w_hs_on ? c_HS_ON : ~c_HS_ON;
      vid.vs  <= w_vs_on ? c_VS_ON : ~c_VS_ON;
      vid.r   <= w_den ? w_r : '0;
      vid.g   <= w_den ? w_g : '0;
      vid.b   <= w_den ? w_b : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vtg_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vtg_pattern_gen
//  Brief    : Directed self-checking bench for vtg_pattern_gen on a 14x7
//             raster (8x4 active): solid, bars, ramp, checker, frame-synchronous
//             pattern switch, enable abort/restart, optional frame stop.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vtg_pattern_gen;

  localparam int HTOT = 14;
  localparam int VTOT = 7;
  localparam int FTOT = HTOT * VTOT;

  logic        clk = 1'b0;
  logic        rstb;
  logic        en;
  logic [1:0]  pat_sel;
  logic [23:0] solid_rgb;
  logic [9:0]  frame_cnt;
  logic        frame_done;
`ifdef VTG_FRAME_STOP_EN
  logic [9:0]  frame_limit;
  logic        stopped;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int fc_exp   = 0;

  vtg_video_if #(.CW(8)) vif ();

  vtg_pattern_gen #(
    .H_ACT(8), .H_FP(2), .H_SW(2), .H_BP(2),
    .V_ACT(4), .V_FP(1), .V_SW(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .CW(8), .FCW(10)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .en         (en),
    .pat_sel    (pat_sel),
    .solid_rgb  (solid_rgb),
`ifdef VTG_FRAME_STOP_EN
    .frame_limit(frame_limit),
    .stopped    (stopped),
`endif
    .vid        (vif),
    .frame_cnt  (frame_cnt),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Hand-derived colour for an active pixel of this 8-pixel-wide raster
  function automatic logic [23:0] exp_rgb(input logic [1:0] pat, input logic [23:0] sol,
                                          input int h, input int v);
    logic [7:0] hb;
    logic [7:0] vb;
    hb = h[7:0];
    vb = v[7:0];
    case (pat)
      2'd0: return sol;
      2'd1: begin
        case (h)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2'd2: return {hb, hb, hb};
      default: return (hb[4] ^ vb[4]) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " den"}, vif.den, 1'b0);
    check({tag, " hs"}, vif.hs, 1'b1);
    check({tag, " vs"}, vif.vs, 1'b1);
    check({tag, " rgb"}, {vif.r, vif.g, vif.b}, 24'h0);
    check({tag, " fdone"}, frame_done, 1'b0);
    check({tag, " fcnt"}, frame_cnt, fc_exp[9:0]);
  endtask

  // Observe n_obs consecutive pixels starting at (0,0); optionally change the
  // pattern inputs right after observing pixel chg_at.
  task automatic run_frame(input logic [1:0] pat, input logic [23:0] sol, input int n_obs,
                           input int chg_at, input logic [1:0] chg_pat, input logic [23:0] chg_sol);
    int    h;
    int    v;
    logic  den_e;
    string t;
    for (int k = 0; k < n_obs; k++) begin
      @(negedge clk);
      h = k % HTOT;
      v = k / HTOT;
      if (k == FTOT - 1) fc_exp = (fc_exp + 1) % 1024;
      den_e = (h < 8) && (v < 4);
      t = $sformatf("p%0d(%0d,%0d)", pat, h, v);
      check({t, " den"}, vif.den, den_e);
      check({t, " hs"}, vif.hs, (h == 10 || h == 11) ? 1'b0 : 1'b1);
      check({t, " vs"}, vif.vs, (v == 5) ? 1'b0 : 1'b1);
      check({t, " rgb"}, {vif.r, vif.g, vif.b}, den_e ? exp_rgb(pat, sol, h, v) : 24'h0);
      check({t, " fdone"}, frame_done, (k == FTOT - 1));
      check({t, " fcnt"}, frame_cnt, fc_exp[9:0]);
      if (k == chg_at) begin
        pat_sel   = chg_pat;
        solid_rgb = chg_sol;
      end
    end
  endtask

  initial begin
    rstb      = 1'b0;
    en        = 1'b0;
    pat_sel   = 2'd0;
    solid_rgb = 24'h0;
`ifdef VTG_FRAME_STOP_EN
    frame_limit = 10'd0;
`endif
    repeat (3) @(negedge clk);
    check_idle("reset");
    rstb = 1'b1;
    @(negedge clk);
    check_idle("idle en=0");

    // Solid, then bars, ramp, checker; each next selection set at frame end
    en        = 1'b1;
    pat_sel   = 2'd0;
    solid_rgb = 24'h123456;
    run_frame(2'd0, 24'h123456, FTOT, FTOT - 1, 2'd1, 24'h0);
    run_frame(2'd1, 24'h0,      FTOT, FTOT - 1, 2'd2, 24'h0);
    run_frame(2'd2, 24'h0,      FTOT, FTOT - 1, 2'd3, 24'h0);
    run_frame(2'd3, 24'h0,      FTOT, FTOT - 1, 2'd0, 24'hA5C3E1);

    // Mid-frame switch at line 2: frame stays solid, next frame is ramp
    run_frame(2'd0, 24'hA5C3E1, FTOT, 2 * HTOT, 2'd2, 24'h0);
    run_frame(2'd2, 24'h0,      FTOT, FTOT - 1, 2'd0, 24'h123456);

    // Abort in line 1, then restart from the origin
    run_frame(2'd0, 24'h123456, HTOT + 4, -1, 2'd0, 24'h123456);
    en = 1'b0;
`ifdef VTG_FRAME_STOP_EN
    fc_exp = 0;
`endif
    repeat (3) begin
      @(negedge clk);
      check_idle("abort");
    end
    en = 1'b1;
    run_frame(2'd0, 24'h123456, FTOT, -1, 2'd0, 24'h123456);

`ifdef VTG_FRAME_STOP_EN
    // Stop after three frames, then clear by dropping enable
    en          = 1'b0;
    frame_limit = 10'd3;
    @(negedge clk);
    fc_exp = 0;
    check("stop pre fcnt", frame_cnt, 10'd0);
    check("stop pre stopped", stopped, 1'b0);
    en = 1'b1;
    repeat (3) run_frame(2'd0, 24'h123456, FTOT, -1, 2'd0, 24'h123456);
    check("stop stopped", stopped, 1'b1);
    repeat (20) begin
      @(negedge clk);
      check_idle("stopped");
      check("stopped hold", stopped, 1'b1);
    end
    en = 1'b0;
    @(negedge clk);
    check("restart stopped", stopped, 1'b0);
    check("restart fcnt", frame_cnt, 10'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
